// File: rtl/stage_seq_pkg.sv
// Shared types and stage encodings for the multicycle stage sequencer.
package stage_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT,
    ST_PAUSE,
    ST_HALT,
    ST_ERROR
  } seq_state_e;

  localparam logic [2:0] STAGE_NONE      = 3'd0;
  localparam logic [2:0] STAGE_FETCH     = 3'd1;
  localparam logic [2:0] STAGE_DECODE    = 3'd2;
  localparam logic [2:0] STAGE_EXECUTE   = 3'd3;
  localparam logic [2:0] STAGE_MEMORY    = 3'd4;
  localparam logic [2:0] STAGE_WRITEBACK = 3'd5;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait-state cycles; expired flags the count reaching MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset_L,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (inc_i) count_d = count_q + 8'd1;
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) count_q <= '0;
    else          count_q <= count_d;
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/stage_sequencer.sv
// Drives the 1..5 Stage sequence with start/step control, halt handling,
// memory wait stalls with timeout, and a retired-instruction counter.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | after reset, Stage=0, waits for Start
//   ST_RUN   | stepping Stage 1..5 one per cycle
//   ST_WAIT  | Stage held at 4 until Mem_Ready or timeout
//   ST_PAUSE | step mode, instruction retired, waits for Start
//   ST_HALT  | halt instruction retired, terminal
//   ST_ERROR | memory wait timed out, terminal
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             Reset_L,
  input  logic             Start,
  input  logic             Step_Mode,
  input  logic             Halt_Instr,
  input  logic             Mem_Access,
  input  logic             Mem_Ready,
  output logic [2:0]       Stage,
  output logic             Running,
  output logic             Halted,
  output logic             Mem_Timeout,
  output logic             Instr_Done,
  output logic [CNT_W-1:0] Instr_Count
);

  seq_state_e       state_q, state_d;
  logic [2:0]       stage_q, stage_d;
  logic             halt_pending_q, halt_pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, timeout_q;
  logic             timer_clr, timer_inc, timer_expired;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .Clock   (Clock),
    .Reset_L (Reset_L),
    .clr_i   (timer_clr),
    .inc_i   (timer_inc),
    .expired (timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    stage_d        = stage_q;
    halt_pending_d = halt_pending_q;
    count_d        = count_q;
    timer_clr      = 1'b0;
    timer_inc      = 1'b0;

    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        stage_d = STAGE_NONE;
        if (Start) begin
          state_d = ST_RUN;
          stage_d = STAGE_FETCH;
        end
      end
      ST_RUN: begin
        case (stage_q)
          STAGE_FETCH:   stage_d = STAGE_DECODE;
          STAGE_DECODE: begin
            stage_d        = STAGE_EXECUTE;
            halt_pending_d = Halt_Instr;
          end
          STAGE_EXECUTE: stage_d = STAGE_MEMORY;
          STAGE_MEMORY: begin
            if (Mem_Access && !Mem_Ready) begin
              state_d   = ST_WAIT;
              timer_inc = 1'b1;
            end else begin
              stage_d = STAGE_WRITEBACK;
            end
          end
          STAGE_WRITEBACK: begin
            count_d = count_q + CNT_W'(1);
            if (halt_pending_q) begin
              state_d        = ST_HALT;
              stage_d        = STAGE_NONE;
              halt_pending_d = 1'b0;
            end else if (Step_Mode) begin
              state_d = ST_PAUSE;
              stage_d = STAGE_NONE;
            end else begin
              stage_d = STAGE_FETCH;
            end
          end
          default: stage_d = STAGE_FETCH;
        endcase
      end
      ST_WAIT: begin
        // Ready takes priority over a simultaneous timeout.
        if (Mem_Ready) begin
          state_d   = ST_RUN;
          stage_d   = STAGE_WRITEBACK;
          timer_clr = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_ERROR;
          stage_d = STAGE_NONE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ST_HALT, ST_ERROR: stage_d = STAGE_NONE;
      default: begin
        state_d = ST_IDLE;
        stage_d = STAGE_NONE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q        <= ST_IDLE;
      stage_q        <= STAGE_NONE;
      halt_pending_q <= 1'b0;
      count_q        <= '0;
      halted_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      stage_q        <= stage_d;
      halt_pending_q <= halt_pending_d;
      count_q        <= count_d;
      halted_q       <= (state_d == ST_HALT);
      timeout_q      <= (state_d == ST_ERROR);
    end
  end

  assign Stage       = stage_q;
  assign Instr_Count = count_q;
  assign Halted      = halted_q;
  assign Mem_Timeout = timeout_q;
  assign Running     = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign Instr_Done  = (stage_q == STAGE_WRITEBACK);

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench: per-instruction reference model queues expected per-cycle
// outputs; a negedge monitor pops and compares.
module tb_stage_sequencer;

  localparam int MEM_TO = 15;
  localparam int CW     = 4;

  logic          Clock, Reset_L, Start, Step_Mode, Halt_Instr, Mem_Access, Mem_Ready;
  logic [2:0]    Stage;
  logic          Running, Halted, Mem_Timeout, Instr_Done;
  logic [CW-1:0] Instr_Count;

  stage_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(MEM_TO)) dut (
    .Clock       (Clock),
    .Reset_L     (Reset_L),
    .Start       (Start),
    .Step_Mode   (Step_Mode),
    .Halt_Instr  (Halt_Instr),
    .Mem_Access  (Mem_Access),
    .Mem_Ready   (Mem_Ready),
    .Stage       (Stage),
    .Running     (Running),
    .Halted      (Halted),
    .Mem_Timeout (Mem_Timeout),
    .Instr_Done  (Instr_Done),
    .Instr_Count (Instr_Count)
  );

  typedef struct packed {
    logic [2:0]    stage;
    logic          run;
    logic          halted;
    logic          to;
    logic          done;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_count  = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic obs_t observe();
    obs_t o;
    o.stage  = Stage;
    o.run    = Running;
    o.halted = Halted;
    o.to     = Mem_Timeout;
    o.done   = Instr_Done;
    o.cnt    = Instr_Count;
    return o;
  endfunction

  function automatic void check(input string nm, input obs_t got, input obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got stage=%0d run=%0b halt=%0b to=%0b done=%0b cnt=%0d, expected stage=%0d run=%0b halt=%0b to=%0b done=%0b cnt=%0d",
                  nm, $time, got.stage, got.run, got.halted, got.to, got.done, got.cnt,
                  exp.stage, exp.run, exp.halted, exp.to, exp.done, exp.cnt);
  endfunction

  // Expected outputs for the cycle now visible, then advance one clock.
  task automatic cyc(input int st, input bit run, input bit hl, input bit to);
    obs_t e;
    e.stage  = 3'(st);
    e.run    = run;
    e.halted = hl;
    e.to     = to;
    e.done   = (st == 5);
    e.cnt    = CW'(m_count % (1 << CW));
    q.push_back(e);
    @(posedge Clock); #1;
  endtask

  // res: 0 continues in RUN, 1 paused, 2 halted, 3 timed out.
  task automatic run_instr(input bit halt, input bit mem, input int lat, input bit step,
                           output int res);
    Start = 1'($urandom); Halt_Instr = 1'($urandom); Mem_Access = 1'($urandom);
    Mem_Ready = 1'($urandom); Step_Mode = 1'($urandom);
    cyc(1, 1, 0, 0);
    Halt_Instr = halt;
    cyc(2, 1, 0, 0);
    Halt_Instr = 1'($urandom); Start = 1'($urandom);
    cyc(3, 1, 0, 0);
    Mem_Access = mem;
    Mem_Ready  = mem ? (lat == 0) : 1'($urandom);
    cyc(4, 1, 0, 0);
    if (mem && lat > 0) begin
      for (int k = 1; k <= lat; k++) begin
        Mem_Access = 1'($urandom);
        Mem_Ready  = (k == lat);
        cyc(4, 1, 0, 0);
        if (k == lat) break;
        if (k == MEM_TO) begin
          res = 3;
          return;
        end
      end
    end
    Step_Mode = step; Mem_Access = 1'($urandom); Mem_Ready = 1'($urandom);
    Halt_Instr = 1'($urandom);
    cyc(5, 1, 0, 0);
    m_count++;
    res = halt ? 2 : (step ? 1 : 0);
  endtask

  task automatic start_after(input int idle);
    Start = 1'b0;
    repeat (idle) cyc(0, 0, 0, 0);
    Start = 1'b1;
    cyc(0, 0, 0, 0);
  endtask

  task automatic term_cycles(input int n, input bit hl, input bit to);
    for (int i = 0; i < n; i++) begin
      Start = (i % 2 == 0);
      cyc(0, 0, hl, to);
    end
  endtask

  task automatic do_reset(input string nm);
    Reset_L = 1'b0;
    #1;
    check(nm, observe(), '0);
    m_count = 0;
    @(posedge Clock); #1;
    check({nm, "_hold"}, observe(), '0);
    Reset_L = 1'b1;
    Start = 1'b0;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge Clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cycle", observe(), e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int res;
    Reset_L = 1'b0; Start = 1'b0; Step_Mode = 1'b0; Halt_Instr = 1'b0;
    Mem_Access = 1'b0; Mem_Ready = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_state", observe(), '0);
    Reset_L = 1'b1;

    // Back-to-back run, then a step-mode pause.
    start_after(2);
    run_instr(0, 0, 0, 0, res);
    run_instr(0, 0, 0, 0, res);
    run_instr(0, 0, 0, 1, res);

    // Three wait cycles before ready.
    start_after(3);
    run_instr(0, 1, 3, 1, res);

    // Step mode: separate start pulses, one instruction each.
    repeat (3) begin
      start_after(2);
      run_instr(0, 0, 0, 1, res);
    end

    // Ready arriving on the timeout cycle wins.
    start_after(1);
    run_instr(0, 1, MEM_TO, 1, res);

    // Random instruction mix; count wraps past 2^CW.
    start_after(1);
    for (int i = 0; i < 40; i++) begin
      bit mem, step;
      int lat;
      mem  = 1'($urandom);
      lat  = $urandom_range(0, MEM_TO);
      step = (i == 39) || ($urandom_range(0, 3) == 0);
      run_instr(0, mem, lat, step, res);
      if (res == 1 && i != 39) start_after($urandom_range(0, 3));
    end
    do_reset("rst_after_random");

    // Halt beats step mode; Start ignored afterwards.
    start_after(1);
    run_instr(0, 0, 0, 0, res);
    run_instr(1, 0, 0, 1, res);
    term_cycles(6, 1, 0);
    do_reset("rst_from_halt");

    // Wait timeout into sticky error.
    start_after(0);
    run_instr(0, 1, MEM_TO + 5, 0, res);
    term_cycles(6, 0, 1);
    do_reset("rst_from_error");

    // Asynchronous reset while stalled in WAIT.
    start_after(1);
    run_instr(0, 0, 0, 0, res);
    Halt_Instr = 1'b0;
    cyc(1, 1, 0, 0);
    cyc(2, 1, 0, 0);
    cyc(3, 1, 0, 0);
    Mem_Access = 1'b1; Mem_Ready = 1'b0;
    cyc(4, 1, 0, 0);
    repeat (3) cyc(4, 1, 0, 0);
    @(negedge Clock); #1;
    do_reset("async_rst_in_wait");
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    @(negedge Clock); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Generates the 3-bit `Stage` sequence (1 Fetch, 2 Decode, 3 Execute, 4 Memory, 5 Write Back) consumed by the stage-enable decoder of the multicycle processor. It adds start and step control, halt-instruction handling, memory wait-state stalls with timeout, and a retired-instruction counter. It sits between the top-level run controls / RAM and the stage-enable decoder, and is the only source of `Stage`.

## Interface
Parameters:
- `CNT_W`, 16: width of `Instr_Count`.
- `MEM_TIMEOUT`, 15: maximum stage-4 wait cycles before error; legal range 1..255.

Ports:
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset_L`  in  1  reset, asynchronous and active-low.
- `Start`  in  1  level, sampled each cycle; leaves IDLE or PAUSE.
- `Step_Mode`  in  1  when 1, pause after each instruction.
- `Halt_Instr`  in  1  decoded halt opcode; valid while `Stage`==2.
- `Mem_Access`  in  1  current instruction reads or writes RAM; valid while `Stage`==4.
- `Mem_Ready`  in  1  RAM access complete this cycle.
- `Stage`  out  3  0 when not executing, else 1..5.
- `Running`  out  1  1 in RUN or WAIT.
- `Halted`  out  1  1 in HALT.
- `Mem_Timeout`  out  1  1 in ERROR (sticky).
- `Instr_Done`  out  1  1 in every cycle where `Stage`==5.
- `Instr_Count`  out  `CNT_W`  count of retired instructions.

## Operation
- States: IDLE, RUN, WAIT, PAUSE, HALT, ERROR.
- Reset values: state IDLE; `Stage`=0; `Running`, `Halted`, `Mem_Timeout` and `Instr_Done` all 0; `Instr_Count`=0; halt_pending=0; wait counter=0.
- **IDLE / PAUSE:** `Start`=1 → RUN with `Stage`=1 on the next cycle. Otherwise hold with `Stage`=0.
- **RUN:** `Stage` advances 1→2→3→4→5 one per cycle.
  - At `Stage`=2: halt_pending ← `Halt_Instr`.
  - At `Stage`=4 with `Mem_Access`=1 and `Mem_Ready`=0: go to WAIT; `Stage` holds 4; wait counter ← 1.
  - At `Stage`=4 otherwise: advance to 5.
  - At `Stage`=5: `Instr_Count` increments (wraps modulo 2^`CNT_W`), then the next state is chosen:
    - halt_pending=1 → HALT, `Stage`=0.
    - else `Step_Mode`=1 → PAUSE, `Stage`=0.
    - else `Stage`=1, staying in RUN.
- **WAIT:** `Stage` stays 4.
  - `Mem_Ready`=1 → RUN with `Stage`=5 next cycle; wait counter cleared.
  - Otherwise, wait counter==`MEM_TIMEOUT` → ERROR, `Stage`=0.
  - Otherwise the wait counter increments.
- **HALT, ERROR:** terminal; `Start` is ignored; only `Reset_L` exits.
- `Start` is ignored in RUN, WAIT, HALT and ERROR.
- `Mem_Access` is ignored outside `Stage`=4; `Halt_Instr` is ignored outside `Stage`=2.

## Timing
- All outputs are registered, except `Instr_Done` and `Running`, which are decoded from the registered state and `Stage`.
- Nominal latency: 5 cycles per instruction.
- Each WAIT cycle adds 1 cycle of latency.
- Start-to-Fetch latency: 1 cycle.
- Simultaneous events:
  - halt_pending and `Step_Mode` at `Stage`=5 → HALT wins.
  - `Mem_Ready`=1 in the same cycle the counter reaches `MEM_TIMEOUT` → ready wins and the sequencer proceeds to `Stage`=5.
- `Instr_Count` updates on the edge that leaves `Stage`=5, so the new value is visible together with the following `Stage`.
- Reset mid-operation, including during WAIT: all outputs and internal state return to reset values immediately (asynchronously); no partial instruction is counted.
- `Step_Mode` is sampled only at `Stage`=5; changing it mid-instruction has no effect until that point.

## Structure
- Package `stage_seq_pkg` holds:
  - the state enum (IDLE, RUN, WAIT, PAUSE, HALT, ERROR);
  - stage constants STAGE_NONE=0, STAGE_FETCH=1, STAGE_DECODE=2, STAGE_EXECUTE=3, STAGE_MEMORY=4, STAGE_WRITEBACK=5.
- One sub-module, `mem_wait_timer`:
  - 8-bit counter with clear, increment and compare-to-`MEM_TIMEOUT`;
  - output `expired` is asserted when the count equals `MEM_TIMEOUT`.
- The main module holds the state register, `Stage` register, halt_pending flag and instruction counter.

## Test plan
- Reset, then hold `Start`=1 with `Mem_Access`=0 for 12 cycles → `Stage` sequence 1,2,3,4,5,1,2,3,4,5,1,2; `Instr_Done` high 2 times; `Instr_Count`=2.
- `Mem_Access`=1 at `Stage`=4 with `Mem_Ready` low for 3 cycles, then high → `Stage` 4 held 4 cycles total, then 5; `Instr_Count` +1.
- `MEM_TIMEOUT`=15 and `Mem_Ready` held 0 → ERROR with `Stage`=0 and `Mem_Timeout`=1 after the 15th wait cycle; further `Start` pulses ignored; `Reset_L` clears it.
- `Halt_Instr`=1 at `Stage`=2 with `Step_Mode`=1 → stages 3,4,5, then `Halted`=1, `Stage`=0; `Instr_Count` incremented; `Start` ignored.
- `Step_Mode`=1, pulse `Start` 3 times, each pulse separated by idle cycles → exactly 3 instructions executed, `Stage`=0 between them, `Instr_Count`=3.
- Assert `Reset_L`=0 while in WAIT at `Stage`=4 → `Stage`=0, `Instr_Count`=0 and `Running`=0 without waiting for a clock edge.
